mem_port_arbiter: RTL and testbench

- Shares the single memory port between two requesters.
  - Port 0: the core's fetch/load/store path.
  - Port 1: a boot-loader/debug master.
- Serialises accesses, holds address/data stable for the memory's fixed read latency, and returns a one-cycle ready pulse plus read data to the winner.
- Sits between the core's memory_address/memory_data_out/memory_write_enable/memory_data_in signals and the memory itself.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/rr_picker.sv | 23 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and limits for the two-port memory arbiter.
// Imported by the arbiter top and its round-robin picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_P0   = 2'b01,
        OWNER_P1   = 2'b10
    } owner_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int unsigned MAX_READ_LATENCY = 4;
    localparam int unsigned CNT_W            = $clog2(MAX_READ_LATENCY);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  ready0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ready1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic [1:0]            owner;

    logic [ADDR_WIDTH-1:0] memory_address;
    logic [DATA_WIDTH-1:0] memory_data_out;
    logic                  memory_write_enable;
    logic [DATA_WIDTH-1:0] memory_data_in;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  memory_data_in,
        output ready0, rdata0, ready1, rdata1, owner,
        output memory_address, memory_data_out, memory_write_enable
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output memory_data_in,
        input  ready0, rdata0, ready1, rdata1, owner,
        input  memory_address, memory_data_out, memory_write_enable
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational two-way round-robin selector: on a tie, grant the port
// that did not win last time.
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_idx_o
);

    always_comb begin
        grant_valid_o = req0_i | req1_i;
        grant_idx_o   = PORT0;
        if (req0_i && req1_i) begin
            grant_idx_o = (last_grant_i == PORT0) ? PORT1 : PORT0;
        end else if (req1_i) begin
            grant_idx_o = PORT1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between two requesters, serialising
// accesses and returning a one-cycle ready pulse plus read data to the winner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY - 1);

    arb_state_e            state_q, state_d;
    logic                  cur_q, cur_d;
    logic                  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic grant_valid;
    logic grant_idx;

    rr_picker u_picker (
        .req0_i        (bus.req0),
        .req1_i        (bus.req1),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_q        <= PORT0;
            last_grant_q <= PORT1;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    cur_d        = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = '0;
                    addr_d       = (grant_idx == PORT1) ? bus.addr1  : bus.addr0;
                    we_d         = (grant_idx == PORT1) ? bus.we1    : bus.we0;
                    wdata_d      = (grant_idx == PORT1) ? bus.wdata1 : bus.wdata0;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else if (cnt_q == LAST_CNT) begin
                    // Only the winner's read register is touched.
                    if (cur_q == PORT1) begin
                        rdata1_d = bus.memory_data_in;
                    end else begin
                        rdata0_d = bus.memory_data_in;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    owner_e owner_w;

    always_comb begin
        owner_w = OWNER_NONE;
        if (state_q != ST_IDLE) begin
            owner_w = (cur_q == PORT1) ? OWNER_P1 : OWNER_P0;
        end
    end

    // Address/data hold their last latched value outside ACCESS; only the
    // write strobe is qualified by state.
    assign bus.memory_address      = addr_q;
    assign bus.memory_data_out     = wdata_q;
    assign bus.memory_write_enable = (state_q == ST_ACCESS) && we_q;

    assign bus.ready0 = (state_q == ST_RESP) && (cur_q == PORT0);
    assign bus.ready1 = (state_q == ST_RESP) && (cur_q == PORT1);
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;
    assign bus.owner  = owner_w;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (READ_LATENCY=2) with a one-stage
// registered memory model behind the arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 2;

    logic clk;
    logic reset;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one register stage, so read data is valid RL=2 edges
    // after the address appears.
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;

    always @(posedge clk) begin
        if (reset) begin
            mem[16]  <= 32'h1234_5678;   // 0x40
            mem[128] <= 32'h2000_0002;   // 0x200
            mem[192] <= 32'h3000_0003;   // 0x300
        end else if (bus.memory_write_enable) begin
            mem[bus.memory_address[9:2]] <= bus.memory_data_out;
        end
        rd_q <= mem[bus.memory_address[9:2]];
    end

    assign bus.memory_data_in = rd_q;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_reqs();
        do_reset();

        // Reset state
        check_eq("rst_owner",  bus.owner, 2'b00);
        check_eq("rst_ready0", bus.ready0, 0);
        check_eq("rst_ready1", bus.ready1, 0);
        check_eq("rst_we",     bus.memory_write_enable, 0);
        check_eq("rst_addr",   bus.memory_address, 0);
        check_eq("rst_dout",   bus.memory_data_out, 0);
        check_eq("rst_rdata0", bus.rdata0, 0);
        check_eq("rst_rdata1", bus.rdata1, 0);

        // Reset during the write ACCESS cycle abandons the transaction
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h80; bus.wdata0 = 32'hCAFE_F00D;
        tick();
        check_eq("rmw_we_access", bus.memory_write_enable, 1);
        reset = 1'b1;
        bus.req0 = 1'b0;
        tick();
        check_eq("rmw_we_after", bus.memory_write_enable, 0);
        check_eq("rmw_ready0",   bus.ready0, 0);
        check_eq("rmw_owner",    bus.owner, 2'b00);
        reset = 1'b0;
        tick();
        check_eq("rmw_ready0_late", bus.ready0, 0);
        check_eq("rmw_owner_late",  bus.owner, 2'b00);

        // Single write on port 0
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h100; bus.wdata0 = 32'hDEAD_BEEF;
        tick();
        check_eq("wr_owner",  bus.owner, 2'b01);
        check_eq("wr_we",     bus.memory_write_enable, 1);
        check_eq("wr_addr",   bus.memory_address, 32'h100);
        check_eq("wr_dout",   bus.memory_data_out, 32'hDEAD_BEEF);
        check_eq("wr_ready0_early", bus.ready0, 0);
        tick();
        check_eq("wr_we_off", bus.memory_write_enable, 0);
        check_eq("wr_ready0", bus.ready0, 1);
        check_eq("wr_ready1", bus.ready1, 0);
        bus.req0 = 1'b0;
        tick();
        check_eq("wr_owner_idle",  bus.owner, 2'b00);
        check_eq("wr_ready0_off",  bus.ready0, 0);
        check_eq("wr_addr_held",   bus.memory_address, 32'h100);

        // Single read on port 1
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h40;
        tick();
        check_eq("rd_owner",  bus.owner, 2'b10);
        check_eq("rd_we",     bus.memory_write_enable, 0);
        check_eq("rd_addr",   bus.memory_address, 32'h40);
        tick();
        check_eq("rd_ready1_early", bus.ready1, 0);
        tick();
        check_eq("rd_ready1", bus.ready1, 1);
        check_eq("rd_ready0", bus.ready0, 0);
        check_eq("rd_rdata1", bus.rdata1, 32'h1234_5678);
        check_eq("rd_rdata0_kept", bus.rdata0, 0);
        bus.req1 = 1'b0;
        tick();
        check_eq("rd_ready1_off", bus.ready1, 0);
        check_eq("rd_rdata1_held", bus.rdata1, 32'h1234_5678);

        // Simultaneous requests after reset alternate 0,1,0,1,0,1
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h200;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h300;
        for (int i = 0; i < 6; i++) begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                tick();
                if (bus.ready0 || bus.ready1) seen = 1'b1;
            end
            check_eq("alt_wait", seen, 1);
            if (seen) begin
                check_eq("alt_port", bus.ready1, (i % 2));
                check_eq("alt_both", bus.ready0 & bus.ready1, 0);
                if (bus.ready1) check_eq("alt_rdata1", bus.rdata1, 32'h3000_0003);
                else            check_eq("alt_rdata0", bus.rdata0, 32'h2000_0002);
            end
        end
        clear_reqs();
        tick();
        check_eq("alt_idle_owner", bus.owner, 2'b00);

        // Persistent single requester reads back the earlier write
        begin
            int cyc;
            int last;
            int n;
            logic r1seen;
            cyc = 0; last = 0; n = 0; r1seen = 1'b0;
            bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h100;
            while (n < 4 && cyc < 40) begin
                tick();
                cyc++;
                if (bus.ready1) r1seen = 1'b1;
                if (bus.ready0) begin
                    if (n > 0) check_eq("persist_gap", cyc - last, RL + 2);
                    last = cyc;
                    n++;
                end
            end
            bus.req0 = 1'b0;
            check_eq("persist_count",  n, 4);
            check_eq("persist_ready1", r1seen, 0);
            check_eq("persist_rdata0", bus.rdata0, 32'hDEAD_BEEF);
        end
        tick();

        // Requester address changes mid-access are ignored
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h200;
        tick();
        check_eq("chg_addr_a", bus.memory_address, 32'h200);
        bus.addr0 = 32'h300;
        tick();
        check_eq("chg_addr_b", bus.memory_address, 32'h200);
        tick();
        check_eq("chg_addr_c",  bus.memory_address, 32'h200);
        check_eq("chg_ready0",  bus.ready0, 1);
        check_eq("chg_rdata0",  bus.rdata0, 32'h2000_0002);
        bus.req0 = 1'b0;
        tick();
        check_eq("chg_addr_idle", bus.memory_address, 32'h200);
        check_eq("chg_owner",     bus.owner, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
